paddle_move_controller: RTL and testbench
=========================================

// Module: paddle_move_controller
// PURPOSE
//  Owns one paddle's vertical position and decides who drives it: the player buttons or a CPU ball tracker.
//  Generates its own move-rate tick, synchronises the buttons, arbitrates, clamps to the play field,
//  and hands control to the CPU after a period of player inactivity. Sits between the board inputs and
//  the paddle/ball renderer and collision logic, which consume paddle_center_row.
// PARAMETERS
//  DISP_ROWS      600    visible rows; reset/recenter row = DISP_ROWS/2
//  ROW_MIN        25     smallest legal paddle_center_row (top clamp)
//  ROW_MAX        579    largest legal paddle_center_row (bottom clamp)
//  TICK_DIV       50000  clk cycles per move tick (>=2); max 1 row moved per tick
//  IDLE_TICKS     2000   consecutive button-free ticks before CPU takes over (>=1)
//  DEADBAND       4      CPU does not move while |ball_row - paddle_center_row| <= DEADBAND
// PORTS
//  clk                input   1   system clock
//  rst_n              input   1   synchronous reset, active low
//  enable             input   1   1 = game running; 0 = freeze all motion and counters
//  recenter           input   1   one-cycle pulse: return paddle to DISP_ROWS/2
//  move_up_control    input   1   asynchronous player up button, active high
//  move_down_control  input   1   asynchronous player down button, active high
//  ball_row           input   12  current ball centre row, synchronous to clk
//  paddle_center_row  output  12  registered paddle centre row
//  cpu_active         output  1   1 = CPU owns the paddle (state CPU)
//  move_tick          output  1   one-clk pulse on each move tick
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): paddle_center_row=DISP_ROWS/2, cpu_active=0, move_tick=0,
//   state=PLAYER, tick/idle counters=0, synchroniser flops=0. Reset wins over every other input.
//  Buttons: two-flop synchroniser each; up_s/dn_s lag the pins by 2 clk. All decisions use up_s/dn_s.
//  Tick: counter 0..TICK_DIV-1 advances while enable=1. move_tick=1 in the cycle the counter reads
//   TICK_DIV-1; counter wraps to 0. enable=0 holds the counter and forces move_tick=0.
//  Recenter: recenter=1 -> next cycle row=DISP_ROWS/2, tick counter=0, no move that cycle.
//   Priority over a coincident tick. State and idle counter are unchanged.
//  FSM (2 states):
//   PLAYER: on each tick, idle counter +1 if up_s==dn_s==0, else cleared to 0. When the increment
//    reaches IDLE_TICKS -> CPU, cpu_active=1 from the next cycle, idle counter cleared.
//   CPU: any cycle with up_s|dn_s=1 (no tick needed) -> PLAYER next cycle, cpu_active=0.
//    The tick in that same cycle uses the player rule.
//   enable=0 freezes the state and the idle counter. The CPU is not left on enable alone.
//  Move, evaluated only on move_tick, applied at the same posedge:
//   Player: up_s&!dn_s -> row-1 if row>ROW_MIN; dn_s&!up_s -> row+1 if row<ROW_MAX;
//    both pressed or none pressed -> hold.
//   CPU: ball_row+DEADBAND < row -> row-1 if row>ROW_MIN;
//    ball_row > row+DEADBAND -> row+1 if row<ROW_MAX; else hold.
//  Arithmetic: comparisons in 13-bit unsigned, so ball_row+DEADBAND cannot wrap.
//   Row never leaves [ROW_MIN,ROW_MAX] once inside. Out-of-range rows are only possible via a bad
//   parameter set; they then step one row per tick toward the legal range.
//  Row changes by at most 1 per tick. Latency: pin change -> row change <= 2 clk + TICK_DIV clk.
// TESTING (bench uses TICK_DIV=4, IDLE_TICKS=8, DEADBAND=4)
//  Reset: rst_n=0 for 2 clk with both buttons high -> row=300, cpu_active=0, move_tick=0;
//   first move_tick arrives 4 clk after rst_n rises.
//  Player up held 20 ticks from 300 -> row=280. At row=25 with up held 5 more ticks -> row stays 25.
//   Both buttons held -> row constant.
//  Takeover: 8 button-free ticks -> cpu_active=1. ball_row=350 from row 300 ->
//   row rises 1/tick, stops at 346. ball_row=303 -> no motion (deadband).
//  Handback: in CPU, pulse down for 3 clk -> cpu_active=0 exactly 3 clk after pin edge (2 sync + 1);
//   idle counter restarts from 0.
//  recenter coincident with move_tick while up held at row 250 -> row=300 next cycle, next tick 4 clk later.
//   enable=0 for 40 clk -> no move_tick, row, state and idle count unchanged.

Source files
------------

// File: rtl/paddle_move_controller.sv
// rtl/paddle_move_controller.sv - paddle position owner: button sync, move tick, player/CPU arbitration, clamping
// One paddle's centre row, moved at most one row per tick by the player or by a ball-tracking CPU.
module paddle_move_controller #(
    parameter int DISP_ROWS  = 600,
    parameter int ROW_MIN    = 25,
    parameter int ROW_MAX    = 579,
    parameter int TICK_DIV   = 50000,
    parameter int IDLE_TICKS = 2000,
    parameter int DEADBAND   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        recenter,
    input  logic        move_up_control,
    input  logic        move_down_control,
    input  logic [11:0] ball_row,
    output logic [11:0] paddle_center_row,
    output logic        cpu_active,
    output logic        move_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS + 1) : 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TICKS - 1);
    localparam logic [11:0]   ROW_CENTER = 12'(DISP_ROWS / 2);
    localparam logic [12:0]   MIN13      = 13'(ROW_MIN);
    localparam logic [12:0]   MAX13      = 13'(ROW_MAX);
    localparam logic [12:0]   DB13       = 13'(DEADBAND);

    typedef enum logic {
        ST_PLAYER = 1'b0,
        ST_CPU    = 1'b1
    } state_t;

    logic          up_meta_q, up_s_q;
    logic          dn_meta_q, dn_s_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [IW-1:0] idle_cnt_q;
    logic [11:0]   row_q, row_d;
    state_t        state_q;
    logic          cpu_active_q;

    logic          tick_fire;
    logic          any_btn;
    logic          player_rule;
    logic          want_up, want_dn;
    logic [12:0]   row13, ball13;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_meta_q <= 1'b0;
            up_s_q    <= 1'b0;
            dn_meta_q <= 1'b0;
            dn_s_q    <= 1'b0;
        end else begin
            up_meta_q <= move_up_control;
            up_s_q    <= up_meta_q;
            dn_meta_q <= move_down_control;
            dn_s_q    <= dn_meta_q;
        end
    end

    assign move_tick   = enable && (tick_cnt_q == TICK_LAST);
    // A recenter consumes a coincident tick: no move and no idle bookkeeping on it.
    assign tick_fire   = move_tick && !recenter;
    assign any_btn     = up_s_q | dn_s_q;
    // A button press in CPU state already drives this cycle's tick by the player rule.
    assign player_rule = (state_q == ST_PLAYER) || any_btn;
    assign row13       = {1'b0, row_q};
    assign ball13      = {1'b0, ball_row};

    always_comb begin
        want_up = 1'b0;
        want_dn = 1'b0;
        if (player_rule) begin
            want_up = up_s_q & ~dn_s_q;
            want_dn = dn_s_q & ~up_s_q;
        end else begin
            want_up = (ball13 + DB13) < row13;
            want_dn = ball13 > (row13 + DB13);
        end
    end

    always_comb begin
        row_d = row_q;
        if (recenter) begin
            row_d = ROW_CENTER;
        end else if (tick_fire) begin
            // Out-of-range rows only come from odd parameters; walk them back in.
            if (row13 < MIN13) begin
                row_d = row_q + 12'd1;
            end else if (row13 > MAX13) begin
                row_d = row_q - 12'd1;
            end else if (want_up && (row13 > MIN13)) begin
                row_d = row_q - 12'd1;
            end else if (want_dn && (row13 < MAX13)) begin
                row_d = row_q + 12'd1;
            end
        end
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (recenter) begin
            tick_cnt_d = '0;
        end else if (enable) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q      <= ROW_CENTER;
            tick_cnt_q <= '0;
        end else begin
            row_q      <= row_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_PLAYER;
            idle_cnt_q   <= '0;
            cpu_active_q <= 1'b0;
        end else if (enable && !recenter) begin
            case (state_q)
                ST_PLAYER: begin
                    if (tick_fire) begin
                        if (any_btn) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q == IDLE_LAST) begin
                            state_q      <= ST_CPU;
                            cpu_active_q <= 1'b1;
                            idle_cnt_q   <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                ST_CPU: begin
                    if (any_btn) begin
                        state_q      <= ST_PLAYER;
                        cpu_active_q <= 1'b0;
                        idle_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_PLAYER;
                    cpu_active_q <= 1'b0;
                    idle_cnt_q   <= '0;
                end
            endcase
        end
    end

    assign paddle_center_row = row_q;
    assign cpu_active        = cpu_active_q;

endmodule

// File: tb/tb_paddle_move_controller.sv
// tb/tb_paddle_move_controller.sv - directed scoreboard bench for paddle_move_controller
// Expected values are queued as each step is driven and popped when the DUT output is sampled.
module tb_paddle_move_controller;

    localparam int TICK_DIV   = 4;
    localparam int IDLE_TICKS = 8;
    localparam int DEADBAND   = 4;
    localparam int CENTER     = 300;
    localparam int ROW_MIN    = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        recenter;
    logic        up;
    logic        dn;
    logic [11:0] ball_row;
    logic [11:0] row;
    logic        cpu_active;
    logic        move_tick;

    int n_checks = 0;
    int n_err    = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 clk = ~clk;

    paddle_move_controller #(
        .DISP_ROWS (600),
        .ROW_MIN   (ROW_MIN),
        .ROW_MAX   (579),
        .TICK_DIV  (TICK_DIV),
        .IDLE_TICKS(IDLE_TICKS),
        .DEADBAND  (DEADBAND)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .recenter         (recenter),
        .move_up_control  (up),
        .move_down_control(dn),
        .ball_row         (ball_row),
        .paddle_center_row(row),
        .cpu_active       (cpu_active),
        .move_tick        (move_tick)
    );

    function automatic void push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endfunction

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        if (val_q.size() == 0) begin
            t = "scoreboard_underflow";
            v = 32'hFFFF_FFFF;
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
        end
        n_checks++;
        assert (obs === v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, v);
        end
    endtask

    // Steps to the negedge where move_tick is seen; k is the number of negedges taken.
    task automatic wait_tick_visible(output int k);
        bit found;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= 4 * TICK_DIV && !found; i++) begin
            @(negedge clk);
            if (move_tick === 1'b1) begin
                found = 1'b1;
                k     = i;
            end
        end
        n_checks++;
        assert (found) else begin
            n_err++;
            $error("FAIL tick_timeout: observed=no move_tick expected=move_tick within %0d clk", 4 * TICK_DIV);
        end
    endtask

    // Waits for the next tick and returns on the negedge after the posedge that consumed it.
    task automatic ticks(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            wait_tick_visible(k);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int seen;

        rst_n    = 1'b0;
        enable   = 1'b1;
        recenter = 1'b0;
        up       = 1'b1;
        dn       = 1'b1;
        ball_row = 12'd0;
        repeat (2) @(negedge clk);
        push("rst_row", CENTER);   check(row);
        push("rst_cpu", 0);        check(cpu_active);
        push("rst_tick", 0);       check(move_tick);

        rst_n = 1'b1;
        up    = 1'b0;
        dn    = 1'b0;
        push("first_tick_clk", TICK_DIV);
        wait_tick_visible(k);
        check(k + 1);

        up = 1'b1;
        push("row_first_tick_idle", CENTER);
        @(negedge clk);
        check(row);

        push("up_1_tick", CENTER - 1);    ticks(1);  check(row);
        push("up_20_ticks", CENTER - 20); ticks(19); check(row);
        push("up_50_ticks", 250);         ticks(30); check(row);

        push("tick_period", TICK_DIV);
        wait_tick_visible(k);
        check(k + 1);
        recenter = 1'b1;
        push("recenter_row", CENTER);
        @(negedge clk);
        recenter = 1'b0;
        check(row);
        push("tick_after_recenter", TICK_DIV);
        wait_tick_visible(k);
        check(k + 1);
        push("row_after_recenter_tick", CENTER - 1);
        @(negedge clk);
        check(row);
        push("cpu_after_recenter", 0); check(cpu_active);

        dn = 1'b1;
        push("both_held", CENTER - 1); ticks(5); check(row);

        dn = 1'b0;
        push("reach_top", ROW_MIN);    ticks(274); check(row);
        push("clamp_top", ROW_MIN);    ticks(5);   check(row);

        up = 1'b0;
        dn = 1'b1;
        push("player_down", ROW_MIN + 10); ticks(10); check(row);

        dn       = 1'b0;
        recenter = 1'b1;
        ball_row = 12'd303;
        push("recenter_idle", CENTER);
        @(negedge clk);
        recenter = 1'b0;
        check(row);
        push("idle_7_cpu", 0);         ticks(7); check(cpu_active);
        push("idle_7_row", CENTER);    check(row);
        push("idle_8_cpu", 1);         ticks(1); check(cpu_active);

        push("deadband_303", CENTER);  ticks(5); check(row);
        ball_row = 12'd304;
        push("deadband_edge_hi", CENTER); ticks(3); check(row);
        ball_row = 12'd296;
        push("deadband_edge_lo", CENTER); ticks(3); check(row);

        ball_row = 12'd350;
        push("cpu_up_1", CENTER + 1);  ticks(1);  check(row);
        push("cpu_up_stop", 346);      ticks(49); check(row);
        ball_row = 12'd303;
        push("cpu_down_stop", 307);    ticks(45); check(row);
        push("cpu_still_active", 1);   check(cpu_active);

        dn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push("handback_2clk", 1);      check(cpu_active);
        @(negedge clk);
        push("handback_3clk", 0);      check(cpu_active);
        dn = 1'b0;
        push("handback_tick_row", 308);
        @(negedge clk);
        check(row);

        push("idle_restart_5", 0);     ticks(5); check(cpu_active);

        enable = 1'b0;
        seen   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (move_tick !== 1'b0) seen++;
        end
        push("freeze_ticks", 0);       check(seen);
        push("freeze_row", 308);       check(row);
        push("freeze_cpu", 0);         check(cpu_active);
        enable = 1'b1;

        push("idle_resume_7", 0);      ticks(2); check(cpu_active);
        push("idle_resume_8", 1);      ticks(1); check(cpu_active);
        push("cpu_after_resume", 307); ticks(1); check(row);

        push("scoreboard_empty", 0);
        check(val_q.size() - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
